// File: rtl/tpu_seq_pkg.sv
// Shared types and TPU address map for the TPU job sequencer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClrC,
    StFetch,
    StWrite,
    StStart,
    StCompute,
    StDrain
  } state_e;

  localparam logic [15:0] A_BASE     = 16'h0100;
  localparam logic [15:0] B_BASE     = 16'h0200;
  localparam logic [15:0] C_BASE     = 16'h0300;
  localparam logic [15:0] START_ADDR = 16'h0400;
  localparam logic [15:0] ROW_STRIDE = 16'h0008;

endpackage

// File: rtl/tpu_seq_addr_gen.sv
// Word-index counter that maps the current index onto the A/B or C region of the TPU map.
module tpu_seq_addr_gen
  import tpu_seq_pkg::*;
#(
  parameter int unsigned DIM      = 8,
  parameter int unsigned NWORDS_C = 16,
  parameter int unsigned ADDRW    = 16,
  parameter int unsigned IDXW     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             sel_c,
  output logic [IDXW-1:0]  idx,
  output logic [ADDRW-1:0] addr,
  output logic             last
);

  always_comb begin
    addr = '0;
    if (sel_c) begin
      addr = ADDRW'(C_BASE) + ADDRW'(idx) * ADDRW'(ROW_STRIDE);
    end else if (idx < IDXW'(DIM)) begin
      addr = ADDRW'(A_BASE) + ADDRW'(idx) * ADDRW'(ROW_STRIDE);
    end else begin
      addr = ADDRW'(B_BASE) + ADDRW'(idx - IDXW'(DIM)) * ADDRW'(ROW_STRIDE);
    end
  end

  assign last = sel_c ? (idx == IDXW'(NWORDS_C - 1)) : (idx == IDXW'(2 * DIM - 1));

  // Wrapping on the last word leaves the index at zero for the next phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/tpu_job_sequencer.sv
// Host-side job sequencer: loads A/B from SRAM into the TPU, starts it, and streams C back out.
module tpu_job_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned DIM            = 8,
  parameter int unsigned BITS_C         = 16,
  parameter int unsigned ADDRW          = 16,
  parameter int unsigned DATAW          = 64,
  parameter int unsigned MEMAW          = 32,
  parameter int unsigned COMPUTE_CYCLES = 3 * DIM - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MEMAW-1:0] cmd_src,
  input  logic             cmd_clear_c,
  output logic             mem_req,
  output logic [MEMAW-1:0] mem_addr,
  input  logic             mem_rvalid,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             tpu_rw,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_din,
  input  logic [DATAW-1:0] tpu_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATAW-1:0] res_data,
  output logic             res_last,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  localparam int unsigned CWords = DIM * ((DIM * BITS_C + DATAW - 1) / DATAW);
  localparam int unsigned MaxW   = (2 * DIM > CWords) ? 2 * DIM : CWords;
  localparam int unsigned IdxW   = $clog2(MaxW);
  localparam int unsigned CntW   = $clog2(COMPUTE_CYCLES + 1);

  state_e            state_q;
  logic [MEMAW-1:0]  src_q;
  logic [CntW-1:0]   cnt_q;
  logic              gen_inc, gen_sel_c, gen_last;
  logic [IdxW-1:0]   gen_idx;
  logic [ADDRW-1:0]  gen_addr;

  assign gen_sel_c = (state_q == StClrC) || (state_q == StDrain);
  assign gen_inc   = (state_q == StClrC) || (state_q == StWrite) ||
                     ((state_q == StDrain) && res_valid && res_ready);

  tpu_seq_addr_gen #(
    .DIM      (DIM),
    .NWORDS_C (CWords),
    .ADDRW    (ADDRW),
    .IDXW     (IdxW)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (gen_inc),
    .sel_c (gen_sel_c),
    .idx   (gen_idx),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  // Bus outputs are loaded on the edge entering the cycle that presents them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      tpu_rw    <= 1'b0;
      tpu_addr  <= '0;
      tpu_din   <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= '0;
      jobs_done <= '0;
    end else begin
      mem_req <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            src_q     <= cmd_src;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_clear_c) begin
              state_q  <= StClrC;
              tpu_rw   <= 1'b1;
              tpu_addr <= ADDRW'(C_BASE);
              tpu_din  <= '0;
            end else begin
              state_q  <= StFetch;
              mem_req  <= 1'b1;
              mem_addr <= cmd_src;
            end
          end
        end
        StClrC: begin
          if (gen_last) begin
            state_q  <= StFetch;
            tpu_rw   <= 1'b0;
            tpu_addr <= '0;
            mem_req  <= 1'b1;
            mem_addr <= src_q;
          end else begin
            tpu_addr <= gen_addr + ADDRW'(ROW_STRIDE);
          end
        end
        StFetch: begin
          if (mem_rvalid) begin
            state_q  <= StWrite;
            tpu_rw   <= 1'b1;
            tpu_addr <= gen_addr;
            tpu_din  <= mem_rdata;
          end
        end
        StWrite: begin
          if (gen_last) begin
            state_q  <= StStart;
            tpu_addr <= ADDRW'(START_ADDR);
            tpu_din  <= '0;
          end else begin
            state_q  <= StFetch;
            tpu_rw   <= 1'b0;
            tpu_addr <= '0;
            tpu_din  <= '0;
            mem_req  <= 1'b1;
            mem_addr <= src_q + MEMAW'(gen_idx) + MEMAW'(1);
          end
        end
        StStart: begin
          state_q  <= StCompute;
          tpu_rw   <= 1'b0;
          tpu_addr <= '0;
          cnt_q    <= CntW'(COMPUTE_CYCLES - 1);
        end
        StCompute: begin
          if (cnt_q == '0) begin
            state_q  <= StDrain;
            tpu_addr <= ADDRW'(C_BASE);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDrain: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_data  <= tpu_dout;
            res_last  <= gen_last;
            tpu_addr  <= '0;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (gen_last) begin
              state_q   <= StIdle;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              jobs_done <= jobs_done + 16'd1;
            end else begin
              tpu_addr <= gen_addr + ADDRW'(ROW_STRIDE);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Self-checking bench: behavioural SRAM and TPU models plus a matrix-level reference for C.
module tb_tpu_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_clear_c;
  logic [31:0] cmd_src;
  logic        mem_req, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        tpu_rw;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_din, tpu_dout;
  logic        res_valid, res_ready, res_last, busy;
  logic [63:0] res_data;
  logic [15:0] jobs_done;

  always #5 clk = ~clk;

  tpu_job_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_clear_c (cmd_clear_c),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .tpu_rw      (tpu_rw),
    .tpu_addr    (tpu_addr),
    .tpu_din     (tpu_din),
    .tpu_dout    (tpu_dout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_last    (res_last),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  int checks = 0;
  int passed = 0;

  // ---------------- environment: SRAM with random latency ----------------
  logic [63:0] sram [256];
  int lat_min = 1;
  int lat_max = 1;

  initial begin
    int a, lat;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_req === 1'b1) begin
        a   = int'(mem_addr & 32'hFF);
        lat = $urandom_range(lat_max, lat_min);
        repeat (lat) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = sram[a];
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
      end
    end
  end

  // ---------------- environment: memory-mapped TPU ----------------
  logic [63:0] a_reg [8]  = '{default: '0};
  logic [63:0] b_reg [8]  = '{default: '0};
  logic [63:0] c_reg [16] = '{default: '0};

  function automatic logic [63:0] mac_word(input int w);
    logic [63:0] res;
    logic [15:0] acc;
    int r, h, av, bv;
    r   = w / 2;
    h   = w % 2;
    res = c_reg[w];
    for (int e = 0; e < 4; e++) begin
      acc = res[16*e +: 16];
      for (int k = 0; k < 8; k++) begin
        av  = $signed(a_reg[r][8*k +: 8]);
        bv  = $signed(b_reg[k][8*(4*h+e) +: 8]);
        acc = acc + 16'(av * bv);
      end
      res[16*e +: 16] = acc;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (tpu_rw === 1'b1) begin
      if (tpu_addr[15:8] == 8'h01) a_reg[tpu_addr[5:3]] <= tpu_din;
      else if (tpu_addr[15:8] == 8'h02) b_reg[tpu_addr[5:3]] <= tpu_din;
      else if (tpu_addr[15:8] == 8'h03) c_reg[tpu_addr[6:3]] <= tpu_din;
      else if (tpu_addr == 16'h0400) begin
        for (int w = 0; w < 16; w++) c_reg[w] <= mac_word(w);
      end
    end
  end

  assign tpu_dout = (tpu_addr >= 16'h0300 && tpu_addr < 16'h0380) ? c_reg[tpu_addr[6:3]] : '0;

  // Bus monitor: START strobes and illegal bus activity.
  int start_cnt = 0;
  int bad_cnt   = 0;
  bit computing = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      computing <= 1'b0;
    end else begin
      if (tpu_addr == 16'h0400) begin
        if (tpu_rw) begin
          start_cnt <= start_cnt + 1;
          computing <= 1'b1;
        end else begin
          bad_cnt <= bad_cnt + 1;
        end
      end else if (computing && tpu_rw) begin
        bad_cnt <= bad_cnt + 1;
      end
      if (res_valid && res_ready && res_last) computing <= 1'b0;
    end
  end

  // ---------------- reference model at matrix level ----------------
  int ma [8][8];
  int mb [8][8];
  int expc [8][8];

  task automatic model_job(input bit clear);
    int acc;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        acc = clear ? 0 : expc[r][c];
        for (int k = 0; k < 8; k++) acc += ma[r][k] * mb[k][c];
        expc[r][c] = acc & 32'hFFFF;
      end
  endtask

  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int e = 0; e < 4; e++) w[16*e +: 16] = 16'(expc[k/2][4*(k%2)+e]);
    return w;
  endfunction

  task automatic load(input int src);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        sram[src+r][8*c +: 8]   = 8'(ma[r][c]);
        sram[src+8+r][8*c +: 8] = 8'(mb[r][c]);
      end
  endtask

  task automatic randomize_mats();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = int'($urandom_range(255, 0)) - 128;
        mb[r][c] = int'($urandom_range(255, 0)) - 128;
      end
  endtask

  // ---------------- drivers ----------------
  logic [63:0] got [16];
  logic        got_last [16];
  bit          timeout;
  int          stall_changed;

  task automatic issue(input bit clear, input int src);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cmd_src     = 32'(src);
    cmd_clear_c = clear;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_src     = $urandom;
    cmd_clear_c = 1'($urandom);
  endtask

  task automatic do_job(input bit clear, input int src, input int stall_k);
    int n;
    logic [63:0] d;
    timeout = 1'b0;
    stall_changed = 0;
    for (int k = 0; k < 16; k++) begin
      got[k] = 'x;
      got_last[k] = 1'bx;
    end
    issue(clear, src);
    for (int k = 0; k < 16; k++) begin
      n = 0;
      while (res_valid !== 1'b1 && n < 2000) begin
        res_ready = 1'($urandom);
        @(negedge clk);
        n++;
      end
      res_ready = 1'b0;
      if (res_valid !== 1'b1) begin
        timeout = 1'b1;
        return;
      end
      if (k == stall_k) begin
        d = res_data;
        repeat (10) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_data !== d) stall_changed++;
        end
      end else begin
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      got[k]      = res_data;
      got_last[k] = res_last;
      res_ready   = 1'b1;
      @(negedge clk);
      res_ready   = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_src     = '0;
    cmd_clear_c = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else passed++;
    checks++; if ({tpu_rw, tpu_addr, tpu_din} !== '0)
      $display("FAIL reset_tpu_bus got %b/%h/%h want 0/0000/0", tpu_rw, tpu_addr, tpu_din);
    else passed++;
    checks++; if ({res_valid, res_last, res_data} !== '0)
      $display("FAIL reset_result got %b/%b/%h want 0/0/0", res_valid, res_last, res_data);
    else passed++;
    checks++; if (jobs_done !== 16'd0) $display("FAIL reset_jobs_done got %0d want 0", jobs_done); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int s0 = start_cnt, b0 = bad_cnt;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r + c;
      end
    load(16);
    model_job(1'b1);
    lat_min = 1; lat_max = 1;
    do_job(1'b1, 16, -1);
    checks++; if (timeout !== 1'b0) $display("FAIL identity_timeout got %b want 0", timeout); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL identity_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
      checks++; if (got_last[k] !== (k == 15))
        $display("FAIL identity_last%0d got %b want %b", k, got_last[k], k == 15);
      else passed++;
    end
    checks++; if (jobs_done !== 16'd1) $display("FAIL identity_jobs got %0d want 1", jobs_done); else passed++;
    checks++; if (start_cnt - s0 !== 1) $display("FAIL identity_starts got %0d want 1", start_cnt - s0); else passed++;
    checks++; if (bad_cnt - b0 !== 0) $display("FAIL identity_bus got %0d want 0", bad_cnt - b0); else passed++;
  endtask

  task automatic test_accumulate();
    model_job(1'b0);
    do_job(1'b0, 16, -1);
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL accum_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
    end
    checks++; if (jobs_done !== 16'd2) $display("FAIL accum_jobs got %0d want 2", jobs_done); else passed++;
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = 127;
        mb[r][c] = 127;
      end
    load(40);
    model_job(1'b1);
    do_job(1'b1, 40, -1);
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== 64'hF808_F808_F808_F808)
        $display("FAIL wrap_word%0d got %h want f808f808f808f808", k, got[k]);
      else passed++;
    end
  endtask

  task automatic test_random_latency();
    int b0 = bad_cnt, s0 = start_cnt;
    randomize_mats();
    load(100);
    model_job(1'b1);
    lat_min = 1; lat_max = 7;
    do_job(1'b1, 100, -1);
    checks++; if (timeout !== 1'b0) $display("FAIL randlat_timeout got %b want 0", timeout); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL randlat_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
    end
    lat_min = 1; lat_max = 1;
    do_job(1'b1, 100, -1);
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL fixedlat_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
    end
    checks++; if (start_cnt - s0 !== 2) $display("FAIL randlat_starts got %0d want 2", start_cnt - s0); else passed++;
    checks++; if (bad_cnt - b0 !== 0) $display("FAIL randlat_bus got %0d want 0", bad_cnt - b0); else passed++;
  endtask

  task automatic test_stall();
    randomize_mats();
    load(160);
    model_job(1'b1);
    lat_min = 1; lat_max = 4;
    do_job(1'b1, 160, 5);
    checks++; if (stall_changed !== 0)
      $display("FAIL stall_stable got %0d changes want 0", stall_changed);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL stall_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
    end
    checks++; if (jobs_done !== 16'd6) $display("FAIL stall_jobs got %0d want 6", jobs_done); else passed++;
  endtask

  task automatic test_reset_mid();
    int s0 = start_cnt, n = 0;
    randomize_mats();
    load(200);
    lat_min = 1; lat_max = 3;
    issue(1'b1, 200);
    while (start_cnt == s0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (start_cnt == s0) $display("FAIL midreset_start got none want 1"); else passed++;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({busy, cmd_ready} !== 2'b01)
      $display("FAIL midreset_state got busy=%b ready=%b want 0/1", busy, cmd_ready);
    else passed++;
    checks++; if ({tpu_rw, tpu_addr, res_valid, jobs_done} !== '0)
      $display("FAIL midreset_outputs got %b/%h/%b/%0d want 0/0000/0/0",
               tpu_rw, tpu_addr, res_valid, jobs_done);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    randomize_mats();
    load(130);
    model_job(1'b1);
    do_job(1'b1, 130, -1);
    for (int k = 0; k < 16; k++) begin
      checks++; if (got[k] !== exp_word(k))
        $display("FAIL postreset_word%0d got %h want %h", k, got[k], exp_word(k));
      else passed++;
    end
    checks++; if (jobs_done !== 16'd1) $display("FAIL postreset_jobs got %0d want 1", jobs_done); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_accumulate();
    test_wrap();
    test_random_latency();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
